// File: rtl/addr_reg_bank_if.sv
// Bus bundle for addr_reg_bank: write path, stack/PC controls, two read ports and sticky stack flags.
interface addr_reg_bank_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
);
    logic [DATA_W-1:0]   i_data;
    logic [2:0]          i_funSel;
    logic [NUM_REGS-1:0] i_regSel;
    logic [1:0]          i_stackOp;
    logic                i_pcInc;
    logic                i_flagClr;
    logic [SEL_W-1:0]    i_outCSel;
    logic [SEL_W-1:0]    i_outDSel;
    logic [DATA_W-1:0]   o_outC;
    logic [DATA_W-1:0]   o_outD;
    logic                o_stackOvf;
    logic                o_stackUnf;

    modport master (
        output i_data, i_funSel, i_regSel, i_stackOp, i_pcInc, i_flagClr,
        output i_outCSel, i_outDSel,
        input  o_outC, o_outD, o_stackOvf, o_stackUnf
    );

    modport slave (
        input  i_data, i_funSel, i_regSel, i_stackOp, i_pcInc, i_flagClr,
        input  i_outCSel, i_outDSel,
        output o_outC, o_outD, o_stackOvf, o_stackUnf
    );
endinterface

// File: rtl/addr_reg_bank.sv
// Address register bank (reg0=PC, reg1=AR, reg2=SP, rest general) with bounded SP push/pop,
// PC auto-increment and two zero-latency read ports.
module addr_reg_bank #(
    parameter int                DATA_W      = 16,
    parameter int                NUM_REGS    = 4,
    parameter logic [DATA_W-1:0] PC_INIT     = '0,
    parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'('h00FF),
    parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'('h00F0)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    addr_reg_bank_if.slave bus
);
    localparam int                HALF   = DATA_W / 2;
    localparam int                PC_IDX = 0;
    localparam int                SP_IDX = 2;
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

    typedef enum logic [1:0] {
        STK_NONE  = 2'b00,
        STK_PUSH  = 2'b01,
        STK_POP   = 2'b10,
        STK_NONE2 = 2'b11
    } stackOp_t;

    logic [DATA_W-1:0] r_regs     [NUM_REGS];
    logic [DATA_W-1:0] w_nextRegs [NUM_REGS];
    logic              r_stackOvf;
    logic              r_stackUnf;
    logic              w_setOvf;
    logic              w_setUnf;
    stackOp_t          w_stackOp;

    function automatic logic [DATA_W-1:0] applyFun(
        input logic [2:0]        fun,
        input logic [DATA_W-1:0] r,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] result;
        case (fun)
            3'b000:  result = r - ONE;
            3'b001:  result = r + ONE;
            3'b010:  result = d;
            3'b011:  result = '0;
            3'b100:  result = {{HALF{1'b0}}, d[HALF-1:0]};
            3'b101:  result = {r[DATA_W-1:HALF], d[HALF-1:0]};
            3'b110:  result = {d[HALF-1:0], r[HALF-1:0]};
            default: result = {{HALF{d[HALF-1]}}, d[HALF-1:0]};
        endcase
        return result;
    endfunction

    assign w_stackOp = stackOp_t'(bus.i_stackOp);

    // A selected register takes the FunSel result; stack/PC side effects only apply when not overridden.
    always_comb begin
        w_setOvf = 1'b0;
        w_setUnf = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_nextRegs[k] = r_regs[k];
            if (!bus.i_regSel[k]) begin
                w_nextRegs[k] = applyFun(bus.i_funSel, r_regs[k], bus.i_data);
            end else if (k == SP_IDX) begin
                case (w_stackOp)
                    STK_PUSH: begin
                        if (r_regs[k] > STACK_LIMIT) w_nextRegs[k] = r_regs[k] - ONE;
                        else                         w_setOvf      = 1'b1;
                    end
                    STK_POP: begin
                        if (r_regs[k] < STACK_BASE)  w_nextRegs[k] = r_regs[k] + ONE;
                        else                         w_setUnf      = 1'b1;
                    end
                    default: ;
                endcase
            end else if (k == PC_IDX && bus.i_pcInc) begin
                w_nextRegs[k] = r_regs[k] + ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (k == PC_IDX)      r_regs[k] <= PC_INIT;
                else if (k == SP_IDX) r_regs[k] <= STACK_BASE;
                else                  r_regs[k] <= '0;
            end
            r_stackOvf <= 1'b0;
            r_stackUnf <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= w_nextRegs[k];
            end
            // A new violation beats a simultaneous clear.
            if (w_setOvf)            r_stackOvf <= 1'b1;
            else if (bus.i_flagClr)  r_stackOvf <= 1'b0;
            if (w_setUnf)            r_stackUnf <= 1'b1;
            else if (bus.i_flagClr)  r_stackUnf <= 1'b0;
        end
    end

    always_comb begin
        bus.o_outC = '0;
        bus.o_outD = '0;
        if (int'(bus.i_outCSel) < NUM_REGS) bus.o_outC = r_regs[bus.i_outCSel];
        if (int'(bus.i_outDSel) < NUM_REGS) bus.o_outD = r_regs[bus.i_outDSel];
    end

    assign bus.o_stackOvf = r_stackOvf;
    assign bus.o_stackUnf = r_stackUnf;
endmodule

// File: tb/tb_addr_reg_bank.sv
// Directed self-checking bench for addr_reg_bank using hand-computed expectations (default parameters).
module tb_addr_reg_bank;
    logic clk;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    addr_reg_bank_if #(.DATA_W(16), .NUM_REGS(4)) bus ();

    addr_reg_bank dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_data    = '0;
        bus.i_funSel  = 3'b000;
        bus.i_regSel  = 4'b1111;
        bus.i_stackOp = 2'b00;
        bus.i_pcInc   = 1'b0;
        bus.i_flagClr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [2:0] fun, input logic [15:0] data);
        bus.i_regSel = sel;
        bus.i_funSel = fun;
        bus.i_data   = data;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        bus.i_outCSel = 2'd0;
        bus.i_outDSel = 2'd2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        assertCount++; if (bus.o_outC !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_pc: got %h expected 0000", bus.o_outC); end
        assertCount++; if (bus.o_outD !== 16'h00FF) begin failCount++; $display("[TB] FAIL reset_sp: got %h expected 00ff", bus.o_outD); end
        assertCount++; if (bus.o_stackOvf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.o_stackOvf); end
        assertCount++; if (bus.o_stackUnf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_unf: got %b expected 0", bus.o_stackUnf); end
    endtask

    task automatic test_pc_funsel();
        bus.i_outCSel = 2'd0;
        applyStimulus(4'b1110, 3'b010, 16'h1234);
        assertCount++; if (bus.o_outC !== 16'h1234) begin failCount++; $display("[TB] FAIL pc_load: got %h expected 1234", bus.o_outC); end
        applyStimulus(4'b1110, 3'b001, 16'h0000);
        assertCount++; if (bus.o_outC !== 16'h1235) begin failCount++; $display("[TB] FAIL pc_inc_fun: got %h expected 1235", bus.o_outC); end
        applyStimulus(4'b1110, 3'b011, 16'h5555);
        assertCount++; if (bus.o_outC !== 16'h0000) begin failCount++; $display("[TB] FAIL pc_clear: got %h expected 0000", bus.o_outC); end
        applyStimulus(4'b1110, 3'b000, 16'h0000);
        assertCount++; if (bus.o_outC !== 16'hFFFF) begin failCount++; $display("[TB] FAIL pc_dec_wrap: got %h expected ffff", bus.o_outC); end
        applyStimulus(4'b1110, 3'b001, 16'h0000);
        assertCount++; if (bus.o_outC !== 16'h0000) begin failCount++; $display("[TB] FAIL pc_inc_wrap: got %h expected 0000", bus.o_outC); end
        bus.i_pcInc = 1'b1;
        tick();
        bus.i_pcInc = 1'b0;
        assertCount++; if (bus.o_outC !== 16'h0001) begin failCount++; $display("[TB] FAIL pc_autoinc: got %h expected 0001", bus.o_outC); end
    endtask

    task automatic test_push_overflow();
        bus.i_outDSel = 2'd2;
        bus.i_stackOp = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        assertCount++; if (bus.o_outD !== 16'h00F0) begin failCount++; $display("[TB] FAIL push15_sp: got %h expected 00f0", bus.o_outD); end
        assertCount++; if (bus.o_stackOvf !== 1'b0) begin failCount++; $display("[TB] FAIL push15_ovf: got %b expected 0", bus.o_stackOvf); end
        tick();
        assertCount++; if (bus.o_outD !== 16'h00F0) begin failCount++; $display("[TB] FAIL push16_sp: got %h expected 00f0", bus.o_outD); end
        assertCount++; if (bus.o_stackOvf !== 1'b1) begin failCount++; $display("[TB] FAIL push16_ovf: got %b expected 1", bus.o_stackOvf); end
        bus.i_flagClr = 1'b1;
        tick();
        assertCount++; if (bus.o_stackOvf !== 1'b1) begin failCount++; $display("[TB] FAIL set_beats_clr: got %b expected 1", bus.o_stackOvf); end
        bus.i_stackOp = 2'b00;
        tick();
        bus.i_flagClr = 1'b0;
        assertCount++; if (bus.o_stackOvf !== 1'b0) begin failCount++; $display("[TB] FAIL flagclr_ovf: got %b expected 0", bus.o_stackOvf); end
        bus.i_stackOp = 2'b10;
        tick();
        bus.i_stackOp = 2'b00;
        assertCount++; if (bus.o_outD !== 16'h00F1) begin failCount++; $display("[TB] FAIL pop_from_limit: got %h expected 00f1", bus.o_outD); end
    endtask

    task automatic test_pop_underflow();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.i_stackOp = 2'b10;
        tick();
        bus.i_stackOp = 2'b00;
        assertCount++; if (bus.o_outD !== 16'h00FF) begin failCount++; $display("[TB] FAIL pop_empty_sp: got %h expected 00ff", bus.o_outD); end
        assertCount++; if (bus.o_stackUnf !== 1'b1) begin failCount++; $display("[TB] FAIL pop_empty_unf: got %b expected 1", bus.o_stackUnf); end
        bus.i_stackOp = 2'b01;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.i_stackOp = 2'b00;
        assertCount++; if (bus.o_outD !== 16'h00FF) begin failCount++; $display("[TB] FAIL reset_push_sp: got %h expected 00ff", bus.o_outD); end
        assertCount++; if (bus.o_stackUnf !== 1'b0 || bus.o_stackOvf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_push_flags: got ovf=%b unf=%b expected 0 0", bus.o_stackOvf, bus.o_stackUnf); end
    endtask

    task automatic test_priority();
        bus.i_outCSel = 2'd0;
        bus.i_outDSel = 2'd2;
        bus.i_stackOp = 2'b01;
        applyStimulus(4'b1011, 3'b010, 16'h0080);
        assertCount++; if (bus.o_outD !== 16'h0080) begin failCount++; $display("[TB] FAIL fun_over_push_sp: got %h expected 0080", bus.o_outD); end
        assertCount++; if (bus.o_stackOvf !== 1'b0) begin failCount++; $display("[TB] FAIL fun_over_push_ovf: got %b expected 0", bus.o_stackOvf); end
        bus.i_stackOp = 2'b01;
        tick();
        bus.i_stackOp = 2'b00;
        assertCount++; if (bus.o_outD !== 16'h0080 || bus.o_stackOvf !== 1'b1) begin failCount++; $display("[TB] FAIL push_below_limit: got sp=%h ovf=%b expected 0080 1", bus.o_outD, bus.o_stackOvf); end
        bus.i_stackOp = 2'b10;
        tick();
        bus.i_stackOp = 2'b00;
        assertCount++; if (bus.o_outD !== 16'h0081) begin failCount++; $display("[TB] FAIL pop_out_of_range: got %h expected 0081", bus.o_outD); end
        applyStimulus(4'b1110, 3'b010, 16'h0005);
        bus.i_pcInc = 1'b1;
        applyStimulus(4'b1110, 3'b011, 16'h0000);
        assertCount++; if (bus.o_outC !== 16'h0000) begin failCount++; $display("[TB] FAIL clear_over_pcinc: got %h expected 0000", bus.o_outC); end
    endtask

    task automatic test_halves();
        bus.i_outCSel = 2'd1;
        applyStimulus(4'b1101, 3'b010, 16'hABCD);
        applyStimulus(4'b1101, 3'b101, 16'h0012);
        assertCount++; if (bus.o_outC !== 16'hAB12) begin failCount++; $display("[TB] FAIL ar_keep_high: got %h expected ab12", bus.o_outC); end
        applyStimulus(4'b1101, 3'b110, 16'h0034);
        assertCount++; if (bus.o_outC !== 16'h3412) begin failCount++; $display("[TB] FAIL ar_load_high: got %h expected 3412", bus.o_outC); end
        applyStimulus(4'b1101, 3'b111, 16'h0080);
        assertCount++; if (bus.o_outC !== 16'hFF80) begin failCount++; $display("[TB] FAIL ar_sext_neg: got %h expected ff80", bus.o_outC); end
        applyStimulus(4'b1101, 3'b111, 16'hFF7F);
        assertCount++; if (bus.o_outC !== 16'h007F) begin failCount++; $display("[TB] FAIL ar_sext_pos: got %h expected 007f", bus.o_outC); end
        applyStimulus(4'b1101, 3'b100, 16'hFF56);
        assertCount++; if (bus.o_outC !== 16'h0056) begin failCount++; $display("[TB] FAIL ar_zext_low: got %h expected 0056", bus.o_outC); end
        bus.i_outCSel = 2'd3;
        bus.i_outDSel = 2'd1;
        applyStimulus(4'b0111, 3'b010, 16'hBEEF);
        assertCount++; if (bus.o_outC !== 16'hBEEF) begin failCount++; $display("[TB] FAIL reg3_read: got %h expected beef", bus.o_outC); end
        assertCount++; if (bus.o_outD !== 16'h0056) begin failCount++; $display("[TB] FAIL ar_untouched: got %h expected 0056", bus.o_outD); end
        applyStimulus(4'b0000, 3'b011, 16'h0000);
        assertCount++; if (bus.o_outC !== 16'h0000 || bus.o_outD !== 16'h0000) begin failCount++; $display("[TB] FAIL multi_clear: got c=%h d=%h expected 0000 0000", bus.o_outC, bus.o_outD); end
    endtask

    initial begin
        reset = 1'b0;
        bus.i_outCSel = 2'd0;
        bus.i_outDSel = 2'd2;
        idle();
        #2;
        test_reset();
        test_pc_funsel();
        test_push_overflow();
        test_pop_underflow();
        test_priority();
        test_halves();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
